// File: rtl/alu_pkg.sv
// Shared definitions for the execute-ALU arbiter: function codes, default
// operand width and the per-port response slot states.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // ALU function select, funct3 encoding
  typedef enum logic [2:0] {
    FN_ADD  = 3'd0,
    FN_SLL  = 3'd1,
    FN_SLT  = 3'd2,
    FN_SLTU = 3'd3,
    FN_XOR  = 3'd4,
    FN_SRL  = 3'd5,
    FN_OR   = 3'd6,
    FN_AND  = 3'd7
  } alu_func_e;

  // Response slot lifecycle: free, waiting on the ALU, holding a result
  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_INFLIGHT,
    SLOT_FULL
  } slot_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bus of the shared execute ALU arbiter.
// master: requesters plus the ALU instance; slave: the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned XLEN = alu_pkg::XLEN_DEFAULT
);

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req_lhs0;
  logic [XLEN-1:0] req_lhs1;
  logic [XLEN-1:0] req_rhs0;
  logic [XLEN-1:0] req_rhs1;
  logic [2:0]      req_func0;
  logic [2:0]      req_func1;
  logic            req_alt0;
  logic            req_alt1;

  logic [XLEN-1:0] alu_lhs;
  logic [XLEN-1:0] alu_rhs;
  logic [2:0]      alu_func;
  logic            alu_alt;
  logic [XLEN-1:0] alu_result;

  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_data0;
  logic [XLEN-1:0] rsp_data1;

  modport master (
    output req_valid, req_lhs0, req_lhs1, req_rhs0, req_rhs1,
           req_func0, req_func1, req_alt0, req_alt1, rsp_ready, alu_result,
    input  req_ready, alu_lhs, alu_rhs, alu_func, alu_alt,
           rsp_valid, rsp_data0, rsp_data1
  );

  modport slave (
    input  req_valid, req_lhs0, req_lhs1, req_rhs0, req_rhs1,
           req_func0, req_func1, req_alt0, req_alt1, rsp_ready, alu_result,
    output req_ready, alu_lhs, alu_rhs, alu_func, alu_alt,
           rsp_valid, rsp_data0, rsp_data1
  );

endinterface

// File: rtl/alu_rsp_slot.sv
// One-entry response slot for a single requester: tracks that port's
// in-flight ALU op, captures its result and presents it until popped.
module alu_rsp_slot
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            accept,
  input  logic [XLEN-1:0] alu_result,
  input  logic            rsp_ready,
  output logic            empty,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data
);

  slot_state_e     state_q;
  slot_state_e     state_d;
  logic [XLEN-1:0] data_q;

  // Slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; flush overrides every transition including the capture
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOT_EMPTY:    if (accept) state_d = SLOT_INFLIGHT;
      SLOT_INFLIGHT: state_d = SLOT_FULL;
      SLOT_FULL:     if (rsp_ready) state_d = SLOT_EMPTY;
      default:       state_d = SLOT_EMPTY;
    endcase
    if (flush) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Capture the ALU result the cycle after issue; held while FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (state_q == SLOT_INFLIGHT && !flush) begin
      data_q <= alu_result;
    end
  end

  assign empty     = (state_q == SLOT_EMPTY);
  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_data  = data_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered execute ALU between the pipeline (port 0) and the
// address/branch helper (port 1): round-robin grant, operand mux, per-port
// response slots and a running count of issued ops.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_arbiter_if.slave  bus,
  output logic [31:0]   issue_count
);

  logic [1:0]  slot_empty;
  logic [1:0]  eligible;
  logic [1:0]  grant;
  logic        last_q;
  logic [31:0] count_q;

  assign eligible = bus.req_valid & slot_empty;

  // Round-robin grant; nothing is granted during flush or reset
  always_comb begin
    grant = '0;
    if (rst_n && !flush) begin
      if (eligible == 2'b11) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
    end
  end

  assign bus.req_ready = grant;

  // Last-granted pointer, moves only on an actual grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (grant[0]) begin
      last_q <= 1'b0;
    end else if (grant[1]) begin
      last_q <= 1'b1;
    end
  end

  // Issued-op counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (|grant) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign issue_count = count_q;

  // ALU operand mux; an idle cycle presents port 0 operands as a harmless ADD
  always_comb begin
    bus.alu_lhs  = bus.req_lhs0;
    bus.alu_rhs  = bus.req_rhs0;
    bus.alu_func = FN_ADD;
    bus.alu_alt  = 1'b0;
    if (grant[1]) begin
      bus.alu_lhs  = bus.req_lhs1;
      bus.alu_rhs  = bus.req_rhs1;
      bus.alu_func = bus.req_func1;
      bus.alu_alt  = bus.req_alt1;
    end else if (grant[0]) begin
      bus.alu_func = bus.req_func0;
      bus.alu_alt  = bus.req_alt0;
    end
  end

  alu_rsp_slot #(.XLEN(XLEN)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .accept     (grant[0]),
    .alu_result (bus.alu_result),
    .rsp_ready  (bus.rsp_ready[0]),
    .empty      (slot_empty[0]),
    .rsp_valid  (bus.rsp_valid[0]),
    .rsp_data   (bus.rsp_data0)
  );

  alu_rsp_slot #(.XLEN(XLEN)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .accept     (grant[1]),
    .alu_result (bus.alu_result),
    .rsp_ready  (bus.rsp_ready[1]),
    .empty      (slot_empty[1]),
    .rsp_valid  (bus.rsp_valid[1]),
    .rsp_data   (bus.rsp_data1)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_alu_arbiter;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] issue_count;

  int checks = 0;
  int errors = 0;

  alu_arbiter_if #(.XLEN(XLEN)) bus();

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic alt);
    logic [4:0] sh;
    sh = b[4:0];
    case (f)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Registered ALU stand-in: result visible the cycle after issue
  always @(posedge clk) begin
    bus.alu_result <= ref_alu(bus.alu_lhs, bus.alu_rhs, bus.alu_func, bus.alu_alt);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          occ [2];
  longint      iss [2];
  logic [31:0] exp_d [2];
  bit          last_p = 1'b1;
  logic [31:0] m_count = '0;
  longint      cyc = 0;
  int          preload_seq = 0;
  int          preload_seen = 0;

  logic [1:0]  m_v;
  logic [1:0]  m_elig;
  logic [1:0]  m_g;
  int          winner;
  logic [31:0] x_lhs, x_rhs;
  logic [2:0]  x_func;
  logic        x_alt;

  always @(negedge clk) begin
    cyc++;
    if (preload_seq != preload_seen) begin
      preload_seen = preload_seq;
      m_count = 32'hFFFF_FFFF;
    end
    if (!rst_n) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      chk("rst_issue_count", 64'(issue_count), 64'h0);
      occ[0] = 1'b0;
      occ[1] = 1'b0;
      last_p = 1'b1;
      m_count = '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        m_v[n]    = occ[n] && (cyc - iss[n] >= 2);
        m_elig[n] = bus.req_valid[n] && !occ[n] && !flush;
      end
      winner = -1;
      if (m_elig[0] && m_elig[1]) winner = (last_p == 1'b0) ? 1 : 0;
      else if (m_elig[0]) winner = 0;
      else if (m_elig[1]) winner = 1;
      m_g = '0;
      if (winner >= 0) m_g[winner] = 1'b1;

      x_lhs = bus.req_lhs0;
      x_rhs = bus.req_rhs0;
      x_func = 3'd0;
      x_alt = 1'b0;
      if (winner == 1) begin
        x_lhs = bus.req_lhs1; x_rhs = bus.req_rhs1;
        x_func = bus.req_func1; x_alt = bus.req_alt1;
      end else if (winner == 0) begin
        x_func = bus.req_func0; x_alt = bus.req_alt0;
      end

      chk("req_ready", 64'(bus.req_ready), 64'(m_g));
      chk("alu_lhs", 64'(bus.alu_lhs), 64'(x_lhs));
      chk("alu_rhs", 64'(bus.alu_rhs), 64'(x_rhs));
      chk("alu_func", 64'(bus.alu_func), 64'(x_func));
      chk("alu_alt", 64'(bus.alu_alt), 64'(x_alt));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_v));
      if (m_v[0]) chk("rsp_data0", 64'(bus.rsp_data0), 64'(exp_d[0]));
      if (m_v[1]) chk("rsp_data1", 64'(bus.rsp_data1), 64'(exp_d[1]));
      chk("issue_count", 64'(issue_count), 64'(m_count));

      for (int n = 0; n < 2; n++) begin
        if (m_v[n] && bus.rsp_ready[n]) occ[n] = 1'b0;
      end
      if (winner >= 0) begin
        occ[winner] = 1'b1;
        iss[winner] = cyc;
        exp_d[winner] = ref_alu(x_lhs, x_rhs, x_func, x_alt);
        m_count = m_count + 32'd1;
        last_p = (winner == 1);
      end
      if (flush) begin
        occ[0] = 1'b0;
        occ[1] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = 2'b11;
    flush = 1'b0;
    repeat (4) step();
  endtask

  task automatic rand_port0();
    bus.req_lhs0  = $urandom();
    bus.req_rhs0  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
    bus.req_func0 = 3'($urandom_range(0, 7));
    bus.req_alt0  = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_port1();
    bus.req_lhs1  = $urandom();
    bus.req_rhs1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
    bus.req_func1 = 3'($urandom_range(0, 7));
    bus.req_alt1  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_lhs0 = '0; bus.req_rhs0 = '0; bus.req_func0 = '0; bus.req_alt0 = 1'b0;
    bus.req_lhs1 = '0; bus.req_rhs1 = '0; bus.req_func1 = '0; bus.req_alt1 = 1'b0;
    repeat (3) step();
    chk("init_rsp_data0", 64'(bus.rsp_data0), 64'h0);
    rst_n = 1'b1;

    // Tie straight after reset: port 0 first, then port 1
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    bus.req_lhs0 = 32'hF0; bus.req_rhs0 = 32'h0F; bus.req_func0 = 3'd4; bus.req_alt0 = 1'b0;
    bus.req_lhs1 = 32'd3;  bus.req_rhs1 = 32'd5;  bus.req_func1 = 3'd0; bus.req_alt1 = 1'b1;
    #1 chk("tie_first_grant", 64'(bus.req_ready), 64'h1);
    step();
    #1 chk("tie_second_grant", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = '0;
    #1;
    chk("tie_rsp_valid0", 64'(bus.rsp_valid), 64'h1);
    chk("tie_xor_data", 64'(bus.rsp_data0), 64'hFF);
    chk("tie_issue_count", 64'(issue_count), 64'h2);
    step();
    #1;
    chk("tie_rsp_valid_both", 64'(bus.rsp_valid), 64'h3);
    chk("tie_sub_data", 64'(bus.rsp_data1), 64'hFFFF_FFFE);
    drain();

    // Port 0 alone, ADD 5+7, response consumed immediately
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b11;
    bus.req_lhs0 = 32'd5; bus.req_rhs0 = 32'd7; bus.req_func0 = 3'd0; bus.req_alt0 = 1'b0;
    #1 chk("add_accept_c0", 64'(bus.req_ready), 64'h1);
    step();
    #1 chk("add_busy_c1", 64'(bus.req_ready), 64'h0);
    step();
    #1;
    chk("add_valid_c2", 64'(bus.rsp_valid), 64'h1);
    chk("add_data_c2", 64'(bus.rsp_data0), 64'd12);
    chk("add_no_accept_c2", 64'(bus.req_ready), 64'h0);
    step();
    #1 chk("add_reaccept_c3", 64'(bus.req_ready), 64'h1);
    step();
    drain();

    // Port 1 response held off for a dozen cycles while port 0 streams
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b01;
    bus.req_lhs1 = 32'd100; bus.req_rhs1 = 32'd23; bus.req_func1 = 3'd0; bus.req_alt1 = 1'b0;
    #1 chk("hold_accept1", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = 2'b11;
    rand_port0();
    for (int i = 0; i < 12; i++) begin
      step();
      rand_port0();
      #1;
      chk("hold_blocked1", 64'(bus.req_ready[1]), 64'h0);
      chk("hold_valid1", 64'(bus.rsp_valid[1]), 64'h1);
      chk("hold_data1", 64'(bus.rsp_data1), 64'd123);
    end
    step();
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b11;
    #1 chk("hold_pop_no_accept", 64'(bus.req_ready), 64'h0);
    step();
    #1 chk("hold_reaccept1", 64'(bus.req_ready), 64'h2);
    step();
    drain();

    // Flush the cycle after an SLT(-1,1) accept
    bus.req_valid = 2'b01;
    bus.req_lhs0 = 32'hFFFF_FFFF; bus.req_rhs0 = 32'd1; bus.req_func0 = 3'd2; bus.req_alt0 = 1'b0;
    #1 chk("flush_accept", 64'(bus.req_ready), 64'h1);
    step();
    flush = 1'b1;
    #1;
    chk("flush_ready_low", 64'(bus.req_ready), 64'h0);
    chk("flush_no_valid_c1", 64'(bus.rsp_valid), 64'h0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_no_valid_c2", 64'(bus.rsp_valid), 64'h0);
    chk("flush_reaccept", 64'(bus.req_ready), 64'h1);
    step();
    drain();

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.rsp_ready[0] = ($urandom_range(0, 3) != 0);
      bus.rsp_ready[1] = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      rand_port0();
      rand_port1();
      step();
    end
    flush = 1'b0;

    // Reset in the middle of traffic
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("midrst_count", 64'(issue_count), 64'h0);
    chk("midrst_data0", 64'(bus.rsp_data0), 64'h0);
    chk("midrst_data1", 64'(bus.rsp_data1), 64'h0);
    chk("midrst_ready", 64'(bus.req_ready), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    #1 chk("midrst_tie_port0", 64'(bus.req_ready), 64'h1);
    step();
    drain();

    // Counter wrap from all-ones
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    preload_seq++;
    step();
    bus.req_valid = 2'b01;
    rand_port0();
    step();
    bus.req_valid = '0;
    #1 chk("count_wrap", 64'(issue_count), 64'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
